// File: rtl/multicycle_datapath_hs.sv
// Multicycle RV32 datapath with a valid/ready memory port, load alignment and store lane steering.
// A two-state bus FSM freezes the architectural state while an access is in flight.
module multicycle_datapath_hs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned REG_COUNT = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        adr_src,
    input  logic        ir_write,
    input  logic [1:0]  result_src,
    input  logic [3:0]  alu_control,
    input  logic [1:0]  alu_src_a,
    input  logic [1:0]  alu_src_b,
    input  logic [2:0]  imm_src,
    input  logic        reg_write,
    input  logic        mem_start,
    input  logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_wr,
    output logic        mem_valid,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        mem_done,
    output logic        misaligned,
    output logic [31:0] instr,
    output logic        zero
);
    localparam int unsigned IDX_W = (REG_COUNT == 16) ? 4 : 5;

    if (REG_COUNT != 32 && REG_COUNT != 16) begin : g_bad_reg_count
        $error("REG_COUNT must be 32 or 16");
    end

    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t state_q, state_d;

    logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  size_q, size_d;
    logic        wr_q, wr_d, fetch_q, fetch_d, pcw_q, pcw_d;
    logic        done_q, done_d, misal_q, misal_d;
    logic [31:0] rf_q [REG_COUNT];

    logic [31:0] imm, src_a, src_b, alu_result, result, rd1, rd2, acc_addr, ld_data;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  acc_size;
    logic        start_ok, misal_det, hs, rf_we;

    function automatic logic reg_ok(input logic [4:0] idx);
        return (REG_COUNT == 32) || !idx[4];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= NOP_INSTR;
            old_pc_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            size_q    <= '0;
            wr_q      <= 1'b0;
            fetch_q   <= 1'b0;
            pcw_q     <= 1'b0;
            done_q    <= 1'b0;
            misal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            old_pc_q  <= old_pc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            size_q    <= size_d;
            wr_q      <= wr_d;
            fetch_q   <= fetch_d;
            pcw_q     <= pcw_d;
            done_q    <= done_d;
            misal_q   <= misal_d;
        end
    end

    // Register file is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rd[IDX_W-1:0]] <= result;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok && !misal_det) state_d = S_REQ;
            S_REQ:  if (mem_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rs1 = ir_q[19:15];
        rs2 = ir_q[24:20];
        rd  = ir_q[11:7];
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0 && reg_ok(rs1)) rd1 = rf_q[rs1[IDX_W-1:0]];
        if (rs2 != '0 && reg_ok(rs2)) rd2 = rf_q[rs2[IDX_W-1:0]];

        case (imm_src)
            3'b000:  imm = {{20{ir_q[31]}}, ir_q[31:20]};
            3'b001:  imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            3'b010:  imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            3'b011:  imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            3'b100:  imm = {ir_q[31:12], 12'h000};
            default: imm = '0;
        endcase

        case (alu_src_a)
            2'b00:   src_a = pc_q;
            2'b01:   src_a = old_pc_q;
            2'b10:   src_a = a_q;
            default: src_a = '0;
        endcase
        case (alu_src_b)
            2'b00:   src_b = b_q;
            2'b01:   src_b = imm;
            2'b10:   src_b = 32'd4;
            default: src_b = '0;
        endcase

        case (alu_control)
            4'b0000: alu_result = src_a + src_b;
            4'b0001: alu_result = src_a - src_b;
            4'b0010: alu_result = src_a & src_b;
            4'b0011: alu_result = src_a | src_b;
            4'b0100: alu_result = src_a ^ src_b;
            4'b0101: alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_result = {31'b0, src_a < src_b};
            4'b0111: alu_result = src_a << src_b[4:0];
            4'b1000: alu_result = src_a >> src_b[4:0];
            4'b1001: alu_result = $signed(src_a) >>> src_b[4:0];
            4'b1010: alu_result = src_b;
            default: alu_result = '0;
        endcase

        case (result_src)
            2'b01:   result = mdr_q;
            2'b10:   result = alu_result;
            default: result = alu_out_q;
        endcase
    end

    always_comb begin
        start_ok  = (state_q == S_IDLE) && mem_start;
        hs        = (state_q == S_REQ) && mem_ready;
        acc_addr  = adr_src ? result : pc_q;
        acc_size  = ir_write ? 3'b010 : ir_q[14:12];
        misal_det = (acc_size[1:0] == 2'b01 && acc_addr[0]) ||
                    (acc_size[1] && acc_addr[1:0] != 2'b00);
        rf_we     = reg_write && (state_q == S_IDLE) && rd != '0 && reg_ok(rd);

        ld_data = mem_rdata;
        case (size_q)
            3'b000, 3'b100: begin
                case (addr_q[1:0])
                    2'd0:    ld_data = {24'b0, mem_rdata[7:0]};
                    2'd1:    ld_data = {24'b0, mem_rdata[15:8]};
                    2'd2:    ld_data = {24'b0, mem_rdata[23:16]};
                    default: ld_data = {24'b0, mem_rdata[31:24]};
                endcase
                if (!size_q[2]) ld_data[31:8] = {24{ld_data[7]}};
            end
            3'b001, 3'b101: begin
                ld_data = {16'b0, addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
                if (!size_q[2]) ld_data[31:16] = {16{ld_data[15]}};
            end
            default: ld_data = mem_rdata;
        endcase

        pc_d      = pc_q;
        old_pc_d  = old_pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        if (state_q == S_IDLE) begin
            a_d       = rd1;
            b_d       = rd2;
            alu_out_d = alu_result;
            if (pc_write && !(mem_start && ir_write)) pc_d = result;
        end
        if (hs && fetch_q) begin
            ir_d     = mem_rdata;
            old_pc_d = pc_q;
            if (pcw_q) pc_d = result;
        end
        if (hs && !fetch_q && !wr_q) mdr_d = ld_data;

        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        size_d  = size_q;
        wr_d    = wr_q;
        fetch_d = fetch_q;
        pcw_d   = pcw_q;
        if (start_ok) begin
            addr_d  = acc_addr;
            size_d  = acc_size;
            fetch_d = ir_write;
            pcw_d   = pc_write;
            wr_d    = mem_we && !ir_write;
            be_d    = 4'b1111;
            wdata_d = '0;
            if (mem_we && !ir_write) begin
                case (acc_size[1:0])
                    2'b00: begin
                        be_d    = 4'b0001 << acc_addr[1:0];
                        wdata_d = {4{b_q[7:0]}};
                    end
                    2'b01: begin
                        be_d    = 4'b0011 << acc_addr[1:0];
                        wdata_d = {2{b_q[15:0]}};
                    end
                    default: wdata_d = b_q;
                endcase
            end
        end
        done_d  = hs;
        misal_d = start_ok && misal_det;
    end

    always_comb begin
        busy       = (state_q == S_REQ);
        mem_valid  = busy;
        mem_wr     = busy && wr_q;
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_be     = be_q;
        mem_wdata  = wdata_q;
        mem_done   = done_q;
        misaligned = misal_q;
        instr      = ir_q;
        zero       = (alu_result == '0);
    end
endmodule

// File: tb/tb_multicycle_datapath_hs.sv
// Scoreboard bench: the stimulus acts as control FSM and memory, the monitor checks every bus handshake.
module tb_multicycle_datapath_hs;
    logic        clk, rst;
    logic        pc_write, adr_src, ir_write, reg_write, mem_start, mem_we, mem_ready;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [3:0]  alu_control;
    logic [2:0]  imm_src;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr, mem_wdata, instr;
    logic [3:0]  mem_be;
    logic        mem_wr, mem_valid, busy, mem_done, misaligned, zero;

    logic [31:0] mem_addr16, mem_wdata16, instr16;
    logic [3:0]  mem_be16;
    logic        mem_wr16, mem_valid16, busy16, mem_done16, misaligned16, zero16;

    multicycle_datapath_hs #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .result_src(result_src), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write), .mem_start(mem_start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_wr(mem_wr), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .mem_done(mem_done), .misaligned(misaligned), .instr(instr), .zero(zero)
    );

    multicycle_datapath_hs #(.REG_COUNT(16)) dut16 (
        .clk(clk), .rst(rst), .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .result_src(result_src), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write), .mem_start(mem_start),
        .mem_we(mem_we), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16), .mem_be(mem_be16),
        .mem_wr(mem_wr16), .mem_valid(mem_valid16), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy16), .mem_done(mem_done16), .misaligned(misaligned16), .instr(instr16),
        .zero(zero16)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wdata;
        bit          chk_wdata;
        int          vcyc;
    } req_t;

    req_t        exp_q[$];
    int          checks = 0, errors = 0;
    int          done_cnt = 0, misal_cnt = 0, exp_done = 0, exp_misal = 0;
    logic [31:0] pc_model;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    // Monitor: compares every handshake against the next expected request.
    int          vcnt = 0;
    bit          unstable = 0, last_hs = 0, hs_now;
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_be;
    logic        snap_wr;
    req_t        r;

    always @(negedge clk) begin
        if (!rst) begin
            vcnt = 0; unstable = 0; last_hs = 0;
        end else begin
            if (mem_done) begin
                done_cnt++;
                chk("done_after_handshake", 32'(last_hs), 32'd1);
            end
            if (misaligned) misal_cnt++;
            hs_now = mem_valid && mem_ready;
            if (mem_valid) begin
                if (vcnt == 0) begin
                    snap_addr = mem_addr; snap_be = mem_be; snap_wr = mem_wr; snap_wdata = mem_wdata;
                end else if (mem_addr !== snap_addr || mem_be !== snap_be ||
                             mem_wr !== snap_wr || mem_wdata !== snap_wdata) begin
                    unstable = 1;
                end
                vcnt++;
            end
            if (hs_now) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", mem_addr, 32'hxxxx_xxxx);
                end else begin
                    r = exp_q.pop_front();
                    chk("req_addr", mem_addr, r.addr);
                    chk("req_be", 32'(mem_be), 32'(r.be));
                    chk("req_wr", 32'(mem_wr), 32'(r.wr));
                    if (r.chk_wdata) chk("req_wdata", mem_wdata, r.wdata);
                    chk("req_valid_cycles", 32'(vcnt), 32'(r.vcyc));
                    chk("req_stable", 32'(unstable), 32'd0);
                end
                vcnt = 0; unstable = 0;
            end
            last_hs = hs_now;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        pc_write = 0; adr_src = 0; ir_write = 0; result_src = 0; alu_control = 0;
        alu_src_a = 0; alu_src_b = 0; imm_src = 0; reg_write = 0; mem_start = 0;
        mem_we = 0; mem_ready = 0;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [3:0] be, input logic wr,
                            input logic [31:0] wd, input int vc);
        req_t n;
        n.addr = a; n.be = be; n.wr = wr; n.wdata = wd; n.chk_wdata = wr; n.vcyc = vc;
        exp_q.push_back(n);
        exp_done++;
    endtask

    // Fetch with PC <= PC + 4; returns in the mem_done cycle.
    task automatic fetch(input logic [31:0] ins, input int stall);
        set_idle();
        ir_write = 1; pc_write = 1; mem_start = 1;
        alu_src_a = 2'b00; alu_src_b = 2'b10; alu_control = 4'b0000; result_src = 2'b10;
        push_req(pc_model, 4'hF, 1'b0, 32'h0, stall + 1);
        pc_model += 4;
        step();
        mem_start = 0;
        repeat (stall) step();
        mem_ready = 1; mem_rdata = ins;
        step();
        set_idle();
    endtask

    task automatic alu_wb(input logic [2:0] isrc, input logic [3:0] op);
        step();
        alu_src_a = 2'b10; alu_src_b = 2'b01; imm_src = isrc; alu_control = op;
        result_src = 2'b10; reg_write = 1;
        step();
        set_idle();
    endtask

    task automatic mem_op(input logic we, input logic [31:0] rdata, input int stall, input logic bad,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
        step();
        alu_src_a = 2'b10; alu_src_b = 2'b01; imm_src = we ? 3'b001 : 3'b000;
        alu_control = 4'b0000; result_src = 2'b10; adr_src = 1; mem_we = we; mem_start = 1;
        if (bad) begin
            exp_misal++;
            step();
            chk("misaligned_pulse", 32'(misaligned), 32'd1);
            chk("misaligned_no_valid", 32'(mem_valid), 32'd0);
            chk("misaligned_not_busy", 32'(busy), 32'd0);
            set_idle();
            step();
            chk("misaligned_one_cycle", 32'(misaligned), 32'd0);
            chk("misaligned_still_idle", 32'(mem_valid), 32'd0);
        end else begin
            push_req(e_addr, e_be, we, e_wd, stall + 1);
            step();
            mem_start = 0;
            repeat (stall) step();
            mem_ready = 1; mem_rdata = rdata;
            step();
            set_idle();
        end
    endtask

    logic [31:0] ld_ins [3] = '{32'h0021_8203, 32'h0021_C203, 32'h0021_9203};
    logic [31:0] ld_exp [3] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0};
    int          done_snap;

    initial begin
        set_idle();
        mem_rdata = '0;
        rst = 0;
        pc_model = 32'h100;
        repeat (2) step();
        chk("reset_valid", 32'(mem_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(mem_done), 32'd0);
        chk("reset_misaligned", 32'(misaligned), 32'd0);
        chk("reset_instr", instr, 32'h0000_0013);
        rst = 1;
        step();

        fetch(32'h0050_0093, 3);
        chk("fetch_ir", instr, 32'h0050_0093);
        chk("fetch_old_pc", dut.old_pc_q, 32'h100);
        alu_wb(3'b000, 4'b0000);                          // x1 = 5
        fetch(32'hAABB_D137, 0); alu_wb(3'b100, 4'b1010); // x2 = AABBD000
        fetch(32'hCDD1_0113, 0); alu_wb(3'b000, 4'b0000); // x2 = AABBCCDD
        fetch(32'h2000_0193, 0); alu_wb(3'b000, 4'b0000); // x3 = 0x200

        fetch(32'h0021_81A3, 0); mem_op(1, 0, 1, 0, 32'h200, 4'b1000, 32'hDDDD_DDDD);
        fetch(32'h0021_9123, 0); mem_op(1, 0, 0, 0, 32'h200, 4'b1100, 32'hCCDD_CCDD);
        fetch(32'h0021_A023, 0); mem_op(1, 0, 0, 0, 32'h200, 4'b1111, 32'hAABB_CCDD);

        for (int i = 0; i < 3; i++) begin
            fetch(ld_ins[i], 0);
            mem_op(0, 32'h80F0_7F01, 2, 0, 32'h200, 4'b1111, 32'h0);
            result_src = 2'b01; reg_write = 1;             // x4 = mdr
            step();
            set_idle();
            fetch(32'h0041_A023, 0);
            mem_op(1, 0, 0, 0, 32'h200, 4'b1111, ld_exp[i]);
        end

        fetch(32'h0011_A203, 0); mem_op(0, 0, 0, 1, 0, 0, 0);
        fetch(32'h0011_9203, 0); mem_op(0, 0, 0, 1, 0, 0, 0);

        fetch(32'h0050_0893, 0); alu_wb(3'b000, 4'b0000); // x17 = 5
        fetch(32'h0008_8293, 0);
        step();
        chk("rc32_x17_read", dut.a_q, 32'd5);
        chk("rc16_x17_read", dut16.a_q, 32'd0);
        alu_src_a = 2'b10; alu_src_b = 2'b00; alu_control = 4'b0001;
        #1;
        chk("rc32_zero_clear", 32'(zero), 32'd0);
        chk("rc16_zero_set", 32'(zero16), 32'd1);
        set_idle();
        fetch(32'hFFF0_0013, 0); alu_wb(3'b000, 4'b0000); // x0 = -1 attempt
        fetch(32'h0000_0293, 0);
        step();
        chk("x0_read_zero", dut.a_q, 32'd0);
        chk("rc16_x0_read_zero", dut16.a_q, 32'd0);

        set_idle();
        ir_write = 1; pc_write = 1; mem_start = 1;
        alu_src_a = 2'b00; alu_src_b = 2'b10; result_src = 2'b10;
        step();
        mem_start = 0;
        step();
        chk("abort_in_req", 32'(mem_valid), 32'd1);
        done_snap = done_cnt;
        rst = 0;
        step();
        chk("abort_valid_low", 32'(mem_valid), 32'd0);
        chk("abort_instr_nop", instr, 32'h0000_0013);
        chk("abort_pc_reset", dut.pc_q, 32'h100);
        rst = 1;
        set_idle();
        pc_model = 32'h100;
        repeat (3) step();
        chk("abort_no_done", 32'(done_cnt), 32'(done_snap));

        fetch(32'h0000_0013, 1);
        repeat (3) step();

        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("misaligned_count", 32'(misal_cnt), 32'(exp_misal));
        chk("pending_requests", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_datapath_hs.md
Name: multicycle_datapath_hs

Overview:
- Parametrised successor to the multicycle RV32 datapath: PC, IR/old-PC, register file, immediate extender, ALU, A/B operand and ALU-output registers, result mux.
- Adds a valid/ready memory handshake with stall, a memory-data register with load alignment and sign-extension, and store byte-lane steering.
- Configurable register count (RV32I or RV32E) and reset PC.
- Sits between the main control FSM and the unified instruction/data memory port.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- REG_COUNT, 32: architectural registers; 32 or 16 legal, anything else is an elaboration error.
- NOP_INSTR, 32'h0000_0013: IR reset value.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- pc_write  in  1  PC <= result (see fetch rule)
- adr_src  in  1  address select: 0 = PC, 1 = result
- ir_write  in  1  marks an access as an instruction fetch
- result_src  in  2  result select: 00 alu_out, 01 mdr, 10 alu_result, 11 reserved (drives alu_out)
- alu_control  in  4  ALU operation
- alu_src_a  in  2  A select: 00 PC, 01 old_pc, 10 reg A
- alu_src_b  in  2  B select: 00 reg B, 01 immediate, 10 constant 4
- imm_src  in  3  immediate format
- reg_write  in  1  register-file write enable
- mem_start  in  1  begin one memory access
- mem_we  in  1  the access is a store
- mem_addr  out  32  bus address, word-aligned
- mem_wdata  out  32  lane-steered store data
- mem_be  out  4  byte enables
- mem_wr  out  1  bus write strobe, valid with mem_valid
- mem_valid  out  1  request valid
- mem_ready  in  1  memory accepts / returns data
- mem_rdata  in  32  read data
- busy  out  1  access in flight; control must hold
- mem_done  out  1  one-cycle pulse on completion
- misaligned  out  1  one-cycle pulse on a rejected access
- instr  out  32  IR contents
- zero  out  1  ALU zero flag

Behaviour:
- Reset (rst=0 at an edge):
  - PC = RESET_PC, IR = NOP_INSTR; old_pc, A/B, alu_out and mdr = 0.
  - FSM goes to IDLE with mem_valid, busy, mem_done and misaligned = 0.
  - Register-file contents are not cleared. x0 always reads 0.
- Reset mid-transaction aborts the access: mem_valid drops after that edge and no mem_done is issued.
- Bus FSM states are IDLE and REQ.
- IDLE, with mem_start=1:
  - Capture the access type: fetch = ir_write; store = mem_we; size = instr[14:12] (fetches are always word); byte offset = address[1:0]; address.
  - If the access is misaligned, pulse misaligned on the next cycle, issue no request and stay in IDLE. Misaligned means: halfword with offset bit 0 = 1, or word with offset != 0.
  - Otherwise go to REQ.
- REQ:
  - mem_valid=1 and busy=1.
  - mem_addr = {addr[31:2], 2'b00}; mem_wr, mem_be and mem_wdata come from registers and stay stable until accepted.
  - Handshake completes on the edge where mem_valid and mem_ready are both 1.
  - On completion: return to IDLE and pulse mem_done on the following cycle.
  - Loads: mdr <= extracted data.
  - Fetches: IR <= mem_rdata, old_pc <= PC, and PC <= result if pc_write was high at mem_start.
  - mem_ready may stall indefinitely.
  - mem_ready=1 while in IDLE is ignored.
- Byte lanes:
  - SB: be = 0001 << off, wdata = B[7:0] replicated 4 times.
  - SH: be = 0011 << off, wdata = B[15:0] replicated twice.
  - SW: be = 1111.
  - Loads and fetches: be = 1111, mem_wr = 0.
- Load extraction (funct3): 000 LB and 100 LBU select byte[off]; 001 LH and 101 LHU select half[off[1]]; 010 LW. Signed loads sign-extend, unsigned loads zero-extend. Other funct3 values load the full word.
- While busy=1:
  - PC, A/B, alu_out and register-file writes are frozen; pc_write and reg_write are ignored.
  - mem_start is ignored.
- While not busy:
  - A/B and alu_out load every cycle.
  - A non-fetch pc_write loads PC immediately.
- A new mem_start is accepted in the same cycle mem_done is high.
- REG_COUNT=16: register index bit 4 = 1 reads as 0, and writes to it are dropped.
- Latency:
  - Minimum access time is 2 cycles from mem_start to mem_done (mem_ready already high).
  - The result mux and ALU are combinational.

Test Plan:
- Reset with RESET_PC=32'h100; fetch with mem_start+ir_write+pc_write, mem_ready held low 3 cycles then high, mem_rdata=32'h00500093 -> mem_addr=32'h100 stable 4 cycles; IR=32'h00500093, old_pc=32'h100, PC=32'h104; one mem_done pulse.
- Store B=32'hAABBCCDD, SB at address 32'h203 -> mem_addr=32'h200, be=1000, wdata=32'hDDDDDDDD, mem_wr=1; SH at address 32'h202 -> be=1100, wdata=32'hCCDDCCDD.
- Load with mem_rdata=32'h80F0_7F01 at offset 2 -> LB mdr=32'hFFFFFFF0, LBU mdr=32'h000000F0, LH mdr=32'hFFFF80F0; result_src=01 drives mdr.
- LW at address 32'h201 -> misaligned pulse, mem_valid never asserts, busy=0; LH at address 32'h201 also faults.
- Assert rst=0 during REQ with mem_ready=0 -> next cycle mem_valid=0, PC=RESET_PC, IR=32'h13, no mem_done.
- REG_COUNT=16: write x17 = 5, then read rs1=17 -> A=0; x0 write of 32'hFFFFFFFF -> reads 0.
